load_store_unit: RTL and testbench

- Memory-stage sequencer between the EX/MEM pipeline register and the word-organised data memory (32-bit words, 4 byte lanes).
- Accepts one load/store request per handshake and computes the byte-lane strobes and the shifted write data.
- Splits word-crossing (misaligned) accesses into two memory transactions.
- Returns sign- or zero-extended load data to the MEM/WB register with a one-cycle response pulse. The pipeline stalls while req_ready is low.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_lane_align.sv | 65 ++++++
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// small decode helpers used by both the sequencer and the lane aligner.
// Purely combinational helpers; no state lives here.
package lsu_pkg;

    // Load/store width encodings carried in instruction bits 14:12
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_WAIT = 2'd3
    } lsu_state_t;

    // Byte-lane mask of an access before it is shifted to its offset.
    // Bit 2 of funct3 only selects sign/zero extension, so the size comes
    // from the two low bits.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Stores have no unsigned variants, so only loads accept 1xx codes
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // An access crosses a word boundary when its bytes spill past lane 3
    function automatic logic is_crossing(input logic [2:0] f3, input logic [1:0] off);
        logic c;
        case (f3[1:0])
            2'b01:   c = (off == 2'd3);
            2'b10:   c = (off != 2'd0);
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment for the load/store unit: store strobes and shifted
// write data for both words of an access, plus load combine/shift/extend.
// Purely combinational (zero latency); no handshake, no backpressure.
//
// Ports:
//   i_funct3   access width / signedness
//   i_off      byte offset within the first word
//   i_cross    access spans two words (selects {i_rdata, i_word0})
//   i_wdata    store data, lane 0 aligned
//   i_rdata    most recent memory read word
//   i_word0    first word of a crossing load
//   o_wr_lo    strobes for the first word, o_wr_hi for the second
//   o_wdata_lo write data for the first word, o_wdata_hi for the second
//   o_ldata    extended load result
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_off,
    input  logic              i_cross,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [DATA_W-1:0] i_word0,
    output logic [3:0]        o_wr_lo,
    output logic [3:0]        o_wr_hi,
    output logic [DATA_W-1:0] o_wdata_lo,
    output logic [DATA_W-1:0] o_wdata_hi,
    output logic [DATA_W-1:0] o_ldata
);

    logic [4:0]          w_shamt;
    logic [7:0]          w_mask8;
    logic [2*DATA_W-1:0] w_wide;
    logic [2*DATA_W-1:0] w_comb;
    logic [DATA_W-1:0]   w_ld;

    assign w_shamt = {i_off, 3'b000};

    // Shifting into a double-width window yields both words of a crossing
    // store at once: the low half goes to w0 and the spill-over to w1.
    assign w_mask8    = {4'b0000, size_mask(i_funct3)} << i_off;
    assign o_wr_lo    = w_mask8[3:0];
    assign o_wr_hi    = w_mask8[7:4];
    assign w_wide     = {{DATA_W{1'b0}}, i_wdata} << w_shamt;
    assign o_wdata_lo = w_wide[DATA_W-1:0];
    assign o_wdata_hi = w_wide[2*DATA_W-1:DATA_W];

    // Loads reverse the same idea: glue the two words, shift down by the offset
    assign w_comb = i_cross ? {i_rdata, i_word0} : {{DATA_W{1'b0}}, i_rdata};
    assign w_ld   = DATA_W'(w_comb >> w_shamt);

    always_comb begin
        o_ldata = w_ld;
        case (i_funct3)
            F3_B:    o_ldata = {{(DATA_W-8){w_ld[7]}}, w_ld[7:0]};
            F3_BU:   o_ldata = {{(DATA_W-8){1'b0}}, w_ld[7:0]};
            F3_H:    o_ldata = {{(DATA_W-16){w_ld[15]}}, w_ld[15:0]};
            F3_HU:   o_ldata = {{(DATA_W-16){1'b0}}, w_ld[15:0]};
            default: o_ldata = w_ld;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage sequencer: one load/store per handshake, word-crossing
// accesses split into two memory transactions on consecutive words.
// Latency: store 1 (2 crossing), load 2 (3 crossing), error 1 cycle after
// the edge following accept; req_ready is low until the response cycle.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake; req_ready high only in IDLE
//   req_we               1 = store, 0 = load
//   req_funct3           width/sign code (instruction bits 14:12)
//   req_addr, req_wdata  byte address and store data
//   mem_waddr/mem_raddr  word index presented to the data memory
//   mem_re, mem_wr       read enable and per-byte write strobes
//   mem_wdata            lane-positioned write data
//   mem_rdata            read data, valid one cycle after mem_re
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata            extended load result (0 for stores and errors)
//   rsp_err              unsupported funct3, qualified by rsp_valid
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic [DM_ADDRESS-3:0] mem_waddr,
    output logic [DM_ADDRESS-3:0] mem_raddr,
    output logic                  mem_re,
    output logic [3:0]            mem_wr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int WA_W = DM_ADDRESS - 2;

    lsu_state_t            r_state;
    logic                  r_we;
    logic [2:0]            r_f3;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_word0;
    logic                  r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic                  r_rsp_err;

    logic [1:0]        w_off;
    logic [WA_W-1:0]   w_w0;
    logic [WA_W-1:0]   w_w1;
    logic [WA_W-1:0]   w_word;
    logic              w_legal;
    logic              w_cross;
    logic              w_in_acc;
    logic [3:0]        w_wr_lo;
    logic [3:0]        w_wr_hi;
    logic [DATA_W-1:0] w_wdata_lo;
    logic [DATA_W-1:0] w_wdata_hi;
    logic [DATA_W-1:0] w_ldata;

    assign w_off   = r_addr[1:0];
    assign w_w0    = r_addr[DM_ADDRESS-1:2];
    // Second word wraps naturally at the top of the word address space
    assign w_w1    = w_w0 + WA_W'(1);
    assign w_legal = f3_legal(r_we, r_f3);
    assign w_cross = is_crossing(r_f3, w_off);

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_funct3   (r_f3),
        .i_off      (w_off),
        .i_cross    (w_cross),
        .i_wdata    (r_wdata),
        .i_rdata    (mem_rdata),
        .i_word0    (r_word0),
        .o_wr_lo    (w_wr_lo),
        .o_wr_hi    (w_wr_hi),
        .o_wdata_lo (w_wdata_lo),
        .o_wdata_hi (w_wdata_hi),
        .o_ldata    (w_ldata)
    );

    // Memory-side outputs decode straight from the registered state and the
    // captured request, so reset forces them inactive without waiting a clock.
    assign w_in_acc  = (r_state == S_ACC0) || (r_state == S_ACC1);
    assign w_word    = (r_state == S_ACC1) ? w_w1 : w_w0;
    assign mem_raddr = w_word;
    assign mem_waddr = w_word;
    assign mem_re    = w_in_acc && !r_we && w_legal;
    assign mem_wdata = (r_state == S_ACC1) ? w_wdata_hi : w_wdata_lo;

    always_comb begin
        mem_wr = 4'b0000;
        if (r_we && w_legal) begin
            if (r_state == S_ACC0) begin
                mem_wr = w_wr_lo;
            end else if (r_state == S_ACC1) begin
                mem_wr = w_wr_hi;
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_f3        <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_word0     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Response flags are single-cycle pulses; rdata holds its value
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_f3    <= req_funct3;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_state <= S_ACC0;
                    end
                end
                S_ACC0: begin
                    if (!w_legal) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else if (w_cross) begin
                        r_state <= S_ACC1;
                    end else if (r_we) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_ACC1: begin
                    if (r_we) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        // Read of w0 issued in ACC0 returns now
                        r_word0 <= mem_rdata;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_rsp_rdata <= w_ldata;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        preload;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [6:0]  mem_waddr;
    logic [6:0]  mem_raddr;
    logic        mem_re;
    logic [3:0]  mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [6:0]  a;
        logic [3:0]  wr;
        logic [31:0] d;
    } wrec_t;

    wrec_t       wq[$];
    logic [6:0]  rq[$];
    logic [7:0]  ref_mem [512];
    logic [31:0] dmem [128];

    int          last_wbase;
    int          last_rbase;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_waddr  (mem_waddr),
        .mem_raddr  (mem_raddr),
        .mem_re     (mem_re),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Data memory: byte-strobed synchronous write, registered read
    always @(posedge clk) begin
        if (preload) begin
            for (int w = 0; w < 128; w++) dmem[w] <= init_word(w);
        end else begin
            for (int i = 0; i < 4; i++)
                if (mem_wr[i]) dmem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
        if (mem_re) mem_rdata <= dmem[mem_raddr];
    end

    // Log every memory transaction seen mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wr != 4'b0000) wq.push_back({mem_waddr, mem_wr, mem_wdata});
            if (mem_re) rq.push_back(mem_raddr);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit legal_of(input bit we, input logic [2:0] f3);
        if (we) return f3 <= 3'd2;
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    // Reference load: gather bytes little-endian, then extend
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int addr);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < size_of(f3); k++) v[8*k +: 8] = ref_mem[(addr + k) % 512];
        if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int addr, input logic [31:0] wd);
        for (int k = 0; k < size_of(f3); k++) ref_mem[(addr + k) % 512] = wd[8*k +: 8];
    endtask

    task automatic issue(input bit we, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_before_issue", req_ready, 1);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
        bit got;
        got = 0;
        lat = -1;
        rd  = 32'h0;
        er  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_rdata;
                er  = rsp_err;
                got = 1;
                break;
            end
        end
        check("rsp_seen", 32'(got), 1);
    endtask

    task automatic do_op(input bit we, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, input string tag);
        int          lat;
        int          nw;
        int          exp_lat;
        bit          legal;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic        er;
        legal   = legal_of(we, f3);
        nw      = ((int'(a) % 4) + size_of(f3) - 1) / 4 + 1;
        exp_rd  = (legal && !we) ? ref_load(f3, int'(a)) : 32'h0;
        exp_lat = !legal ? 1 : (we ? nw : nw + 1);
        last_wbase = wq.size();
        last_rbase = rq.size();
        issue(we, f3, a, wd);
        wait_rsp(lat, rd, er);
        last_rd = rd;
        check($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s_err", tag), {31'b0, er}, {31'b0, !legal});
        check($sformatf("%s_rdata", tag), rd, exp_rd);
        check($sformatf("%s_nwrites", tag), 32'(wq.size() - last_wbase), (legal && we) ? 32'(nw) : 0);
        check($sformatf("%s_nreads", tag), 32'(rq.size() - last_rbase), (legal && !we) ? 32'(nw) : 0);
        @(negedge clk);
        check($sformatf("%s_pulse", tag), {31'b0, rsp_valid}, 0);
        check($sformatf("%s_hold", tag), rsp_rdata, rd);
        if (legal && we) ref_store(f3, int'(a), wd);
    endtask

    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0] st_f3 [3] = '{3'd0, 3'd1, 3'd2};

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [31:0] iw;
        logic        er;
        bit          saw;
        int          mm;

        for (int w = 0; w < 128; w++) begin
            iw = init_word(w);
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = iw[8*b +: 8];
        end
        reset      = 1'b1;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 9'h0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        preload = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'b0, req_ready}, 1);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", {31'b0, rsp_err}, 0);
        check("reset_mem_re", {31'b0, mem_re}, 0);
        check("reset_mem_wr", {28'b0, mem_wr}, 0);
        reset = 1'b0;

        // Aligned word store
        do_op(1, 3'b010, 9'h010, 32'hDEADBEEF, "sw_aligned");
        check("sw_aligned_tx", wq[last_wbase], {7'd4, 4'b1111, 32'hDEADBEEF});

        // Byte store in the top lane, then signed and unsigned byte loads
        do_op(1, 3'b000, 9'h013, 32'h000000A5, "sb");
        check("sb_tx", wq[last_wbase], {7'd4, 4'b1000, 32'hA5000000});
        do_op(0, 3'b000, 9'h013, 32'h0, "lb");
        check("lb_value", last_rd, 32'hFFFFFFA5);
        do_op(0, 3'b100, 9'h013, 32'h0, "lbu");
        check("lbu_value", last_rd, 32'h000000A5);

        // Word store crossing words 3/4, read back with a crossing load
        do_op(1, 3'b010, 9'h00E, 32'h11223344, "sw_cross");
        check("sw_cross_tx0", wq[last_wbase], {7'd3, 4'b1100, 32'h33440000});
        check("sw_cross_tx1", wq[last_wbase + 1], {7'd4, 4'b0011, 32'h00001122});
        do_op(0, 3'b010, 9'h00E, 32'h0, "lw_cross");
        check("lw_cross_value", last_rd, 32'h11223344);

        // Halfword access wrapping from the last word to word 0
        do_op(1, 3'b000, 9'h1FF, 32'h00000080, "sb_top");
        do_op(1, 3'b000, 9'h000, 32'h0000007F, "sb_bot");
        do_op(0, 3'b001, 9'h1FF, 32'h0, "lh_wrap");
        check("lh_wrap_raddr0", {25'b0, rq[last_rbase]}, 127);
        check("lh_wrap_raddr1", {25'b0, rq[last_rbase + 1]}, 0);
        check("lh_wrap_value", last_rd, 32'h00007F80);
        do_op(0, 3'b101, 9'h1FF, 32'h0, "lhu_wrap");
        check("lhu_wrap_value", last_rd, 32'h00007F80);

        // Unsupported funct3 on a load and on a store
        do_op(0, 3'b011, 9'h044, 32'h0, "load_f3_011");
        do_op(1, 3'b100, 9'h048, 32'h12345678, "store_f3_100");

        // Back-to-back: second request waits through ACC0, accepted in response cycle
        issue(1, 3'b010, 9'h020, 32'hCAFEF00D);
        ref_store(3'b010, 32'h020, 32'hCAFEF00D);
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 9'h020;
        req_valid  = 1'b1;
        @(negedge clk);
        check("b2b_not_ready_acc0", {31'b0, req_ready}, 0);
        @(negedge clk);
        check("b2b_first_rsp", {31'b0, rsp_valid}, 1);
        check("b2b_ready_in_rsp", {31'b0, req_ready}, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("b2b_accepted", {31'b0, req_ready}, 0);
        wait_rsp(lat, rd, er);
        check("b2b_second_latency", 32'(lat), 2);
        check("b2b_second_value", rd, 32'hCAFEF00D);

        // Reset during ACC1 of a crossing load
        issue(0, 3'b010, 9'h021, 32'h0);
        @(posedge clk);
        #1;
        check("rst_acc1_mem_re", {31'b0, mem_re}, 1);
        reset = 1'b1;
        #1;
        check("rst_async_mem_re", {31'b0, mem_re}, 0);
        check("rst_async_mem_wr", {28'b0, mem_wr}, 0);
        check("rst_async_ready", {31'b0, req_ready}, 1);
        check("rst_async_rdata", rsp_rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        saw = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) saw = 1;
        end
        check("rst_no_rsp", 32'(saw), 0);
        check("rst_ready_after", {31'b0, req_ready}, 1);

        // Randomized mix against the byte-array model
        for (int n = 0; n < 80; n++) begin
            bit          we;
            logic [2:0]  f3;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we)                   f3 = st_f3[$urandom_range(0, 2)];
            else                           f3 = ld_f3[$urandom_range(0, 4)];
            do_op(we, f3, 9'($urandom_range(0, 511)), $urandom, $sformatf("rnd%0d", n));
        end

        // Memory contents must match every store the model accepted
        mm = 0;
        for (int b = 0; b < 512; b++) begin
            iw = dmem[b / 4];
            if (iw[8*(b % 4) +: 8] !== ref_mem[b]) mm++;
        end
        check("final_memory_bytes_differing", 32'(mm), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
